// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded CPU control path: opcodes, T-state
// encoding and the packed control word driven onto the datapath.
package cpu_pkg;

    localparam int OP_W_DEF = 4;

    localparam logic [3:0] OPC_NOP = 4'b0000;
    localparam logic [3:0] OPC_LDA = 4'b0001;
    localparam logic [3:0] OPC_ADD = 4'b0010;
    localparam logic [3:0] OPC_SUB = 4'b0011;
    localparam logic [3:0] OPC_STA = 4'b0100;
    localparam logic [3:0] OPC_LDI = 4'b0101;
    localparam logic [3:0] OPC_JMP = 4'b0110;
    localparam logic [3:0] OPC_JC  = 4'b0111;
    localparam logic [3:0] OPC_JZ  = 4'b1000;
    localparam logic [3:0] OPC_OUT = 4'b1110;
    localparam logic [3:0] OPC_HLT = 4'b1111;

    // T-states use their own number so tstate can be driven straight from the register.
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    typedef struct packed {
        logic pc_rd;
        logic ir_rd;
        logic ram_rd;
        logic a_rd;
        logic alu_rd;
        logic pc_wr;
        logic mar_wr;
        logic ir_wr;
        logic ram_wr;
        logic a_wr;
        logic b_wr;
        logic out_wr;
        logic pc_inc;
        logic alu_sub;
        logic flags_wr;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OPC_ADD) || (op == OPC_SUB);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode: maps (T-state, opcode, flags) to the control word
// and reports whether this step ends the instruction or enters HALT.
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  state_e          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry_flag,
    input  logic            zero_flag,
    output ctrl_word_t      ctrl,
    output logic            last_step,
    output logic            enter_halt
);

    logic [3:0] op;
    assign op = opcode[3:0];

    always_comb begin
        ctrl       = CTRL_IDLE;
        last_step  = 1'b0;
        enter_halt = 1'b0;
        case (state)
            ST_T0: begin
                ctrl.pc_rd  = 1'b1;
                ctrl.mar_wr = 1'b1;
            end
            ST_T1: begin
                ctrl.ram_rd = 1'b1;
                ctrl.ir_wr  = 1'b1;
                ctrl.pc_inc = 1'b1;
            end
            ST_T2: begin
                case (op)
                    OPC_LDA, OPC_ADD, OPC_SUB, OPC_STA: begin
                        ctrl.ir_rd  = 1'b1;
                        ctrl.mar_wr = 1'b1;
                    end
                    OPC_LDI: begin
                        ctrl.ir_rd = 1'b1;
                        ctrl.a_wr  = 1'b1;
                        last_step  = 1'b1;
                    end
                    OPC_JMP: begin
                        ctrl.ir_rd = 1'b1;
                        ctrl.pc_wr = 1'b1;
                        last_step  = 1'b1;
                    end
                    OPC_JC: begin
                        ctrl.ir_rd = carry_flag;
                        ctrl.pc_wr = carry_flag;
                        last_step  = 1'b1;
                    end
                    OPC_JZ: begin
                        ctrl.ir_rd = zero_flag;
                        ctrl.pc_wr = zero_flag;
                        last_step  = 1'b1;
                    end
                    OPC_OUT: begin
                        ctrl.a_rd   = 1'b1;
                        ctrl.out_wr = 1'b1;
                        last_step   = 1'b1;
                    end
                    OPC_HLT: enter_halt = 1'b1;
                    // NOP and every undefined opcode fall through to a bare T2.
                    default: last_step = 1'b1;
                endcase
            end
            ST_T3: begin
                if (op == OPC_LDA) begin
                    ctrl.ram_rd = 1'b1;
                    ctrl.a_wr   = 1'b1;
                    last_step   = 1'b1;
                end else if (op == OPC_STA) begin
                    ctrl.a_rd   = 1'b1;
                    ctrl.ram_wr = 1'b1;
                    last_step   = 1'b1;
                end else if (is_alu_op(op)) begin
                    ctrl.ram_rd = 1'b1;
                    ctrl.b_wr   = 1'b1;
                end else begin
                    last_step = 1'b1;
                end
            end
            ST_T4: begin
                if (is_alu_op(op)) begin
                    ctrl.alu_rd   = 1'b1;
                    ctrl.a_wr     = 1'b1;
                    ctrl.flags_wr = 1'b1;
                    ctrl.alu_sub  = (op == OPC_SUB);
                end
                last_step = 1'b1;
            end
            ST_HALT: ;
            // T5 is reserved and any stray encoding recovers to T0 silently.
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// T-state sequencer: owns the state register and gates the decoded control
// word with run and reset; all microcode lives in ctrl_decode.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            run,
    input  logic [OP_W-1:0] ir_opcode,
    input  logic            carry_flag,
    input  logic            zero_flag,
    output logic            pc_rd,
    output logic            ir_rd,
    output logic            ram_rd,
    output logic            a_rd,
    output logic            alu_rd,
    output logic            pc_wr,
    output logic            mar_wr,
    output logic            ir_wr,
    output logic            ram_wr,
    output logic            a_wr,
    output logic            b_wr,
    output logic            out_wr,
    output logic            pc_inc,
    output logic            alu_sub,
    output logic            flags_wr,
    output logic [2:0]      tstate,
    output logic            halted
);

    state_e     state_reg;
    state_e     state_next;
    ctrl_word_t dec_ctrl;
    ctrl_word_t ctrl_out;
    logic       last_step;
    logic       enter_halt;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .state      (state_reg),
        .opcode     (ir_opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (dec_ctrl),
        .last_step  (last_step),
        .enter_halt (enter_halt)
    );

    always_comb begin
        state_next = state_reg;
        if (run && state_reg != ST_HALT) begin
            if (enter_halt)
                state_next = ST_HALT;
            else if (last_step)
                state_next = ST_T0;
            else
                state_next = state_e'(state_reg + 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n)
            state_reg <= ST_T0;
        else
            state_reg <= state_next;
    end

    // Reset is visible immediately on the outputs, not only after the edge.
    assign ctrl_out = (clr_n && run) ? dec_ctrl : CTRL_IDLE;
    assign tstate   = clr_n ? state_reg : 3'd0;
    assign halted   = clr_n && (state_reg == ST_HALT);

    assign pc_rd    = ctrl_out.pc_rd;
    assign ir_rd    = ctrl_out.ir_rd;
    assign ram_rd   = ctrl_out.ram_rd;
    assign a_rd     = ctrl_out.a_rd;
    assign alu_rd   = ctrl_out.alu_rd;
    assign pc_wr    = ctrl_out.pc_wr;
    assign mar_wr   = ctrl_out.mar_wr;
    assign ir_wr    = ctrl_out.ir_wr;
    assign ram_wr   = ctrl_out.ram_wr;
    assign a_wr     = ctrl_out.a_wr;
    assign b_wr     = ctrl_out.b_wr;
    assign out_wr   = ctrl_out.out_wr;
    assign pc_inc   = ctrl_out.pc_inc;
    assign alu_sub  = ctrl_out.alu_sub;
    assign flags_wr = ctrl_out.flags_wr;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instruction sequences push
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_control_unit;

    localparam logic [14:0] PC_RD    = 15'b100000000000000;
    localparam logic [14:0] IR_RD    = 15'b010000000000000;
    localparam logic [14:0] RAM_RD   = 15'b001000000000000;
    localparam logic [14:0] A_RD     = 15'b000100000000000;
    localparam logic [14:0] ALU_RD   = 15'b000010000000000;
    localparam logic [14:0] PC_WR    = 15'b000001000000000;
    localparam logic [14:0] MAR_WR   = 15'b000000100000000;
    localparam logic [14:0] IR_WR    = 15'b000000010000000;
    localparam logic [14:0] RAM_WR   = 15'b000000001000000;
    localparam logic [14:0] A_WR     = 15'b000000000100000;
    localparam logic [14:0] B_WR     = 15'b000000000010000;
    localparam logic [14:0] OUT_WR   = 15'b000000000001000;
    localparam logic [14:0] PC_INC   = 15'b000000000000100;
    localparam logic [14:0] ALU_SUB  = 15'b000000000000010;
    localparam logic [14:0] FLAGS_WR = 15'b000000000000001;
    localparam logic [14:0] NONE     = 15'b000000000000000;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic pc_rd, ir_rd, ram_rd, a_rd, alu_rd, pc_wr, mar_wr, ir_wr, ram_wr;
    logic a_wr, b_wr, out_wr, pc_inc, alu_sub, flags_wr, halted;
    logic [2:0] tstate;

    typedef struct {
        logic        chk_ts;
        logic [2:0]  ts;
        logic        h;
        logic [14:0] w;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    control_unit #(.OP_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .ir_opcode(ir_opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_rd(pc_rd), .ir_rd(ir_rd), .ram_rd(ram_rd), .a_rd(a_rd), .alu_rd(alu_rd),
        .pc_wr(pc_wr), .mar_wr(mar_wr), .ir_wr(ir_wr), .ram_wr(ram_wr), .a_wr(a_wr),
        .b_wr(b_wr), .out_wr(out_wr), .pc_inc(pc_inc), .alu_sub(alu_sub),
        .flags_wr(flags_wr), .tstate(tstate), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [14:0] act_w;
    assign act_w = {pc_rd, ir_rd, ram_rd, a_rd, alu_rd, pc_wr, mar_wr, ir_wr,
                    ram_wr, a_wr, b_wr, out_wr, pc_inc, alu_sub, flags_wr};

    // Monitor: bus-drive exclusivity every cycle, plus scoreboard entries when queued.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        n_cmp++;
        if ($countones({pc_rd, ir_rd, ram_rd, a_rd, alu_rd}) > 1) begin
            n_bad++;
            $display("FAIL rd_exclusive @%0t: rd bits=%b, required at most one high",
                     $time, {pc_rd, ir_rd, ram_rd, a_rd, alu_rd});
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act_w !== e.w || halted !== e.h || (e.chk_ts && tstate !== e.ts)) begin
                n_bad++;
                $display("FAIL %s @%0t: got ts=%0d halted=%b ctrl=%b, want ts=%0d halted=%b ctrl=%b",
                         nm, $time, tstate, halted, act_w, e.ts, e.h, e.w);
            end
        end
    end

    task automatic drive(input logic r, input logic cl, input logic [3:0] op,
                         input logic c, input logic z);
        run = r; clr_n = cl; ir_opcode = op; carry_flag = c; zero_flag = z;
    endtask

    task automatic step(input logic r, input logic cl, input logic [3:0] op,
                        input logic c, input logic z, input logic chk_ts,
                        input logic [2:0] ts, input logic h, input logic [14:0] w,
                        input string nm);
        exp_t e;
        drive(r, cl, op, c, z);
        e.chk_ts = chk_ts; e.ts = ts; e.h = h; e.w = w;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [3:0] op, input logic c, input logic z, input string nm);
        step(1, 1, op, c, z, 1, 3'd0, 0, PC_RD | MAR_WR, {nm, "_t0"});
        step(1, 1, op, c, z, 1, 3'd1, 0, RAM_RD | IR_WR | PC_INC, {nm, "_t1"});
    endtask

    task automatic short_instr(input logic [3:0] op, input logic c, input logic z,
                               input logic [14:0] w2, input string nm);
        fetch(op, c, z, nm);
        step(1, 1, op, c, z, 1, 3'd2, 0, w2, {nm, "_t2"});
    endtask

    task automatic alu_instr(input logic [3:0] op, input logic [14:0] sub, input string nm);
        fetch(op, 0, 0, nm);
        step(1, 1, op, 0, 0, 1, 3'd2, 0, IR_RD | MAR_WR, {nm, "_t2"});
        step(1, 1, op, 0, 0, 1, 3'd3, 0, RAM_RD | B_WR, {nm, "_t3"});
        step(1, 1, op, 0, 0, 1, 3'd4, 0, ALU_RD | A_WR | FLAGS_WR | sub, {nm, "_t4"});
    endtask

    initial begin
        logic [3:0] cur_op;
        @(posedge clk); #1;
        // Reset holds everything low regardless of run.
        step(1, 0, 4'h5, 0, 0, 1, 3'd0, 0, NONE, "reset_a");
        step(1, 0, 4'h5, 0, 0, 1, 3'd0, 0, NONE, "reset_b");

        short_instr(4'h5, 0, 0, IR_RD | A_WR, "ldi");
        alu_instr(4'h3, ALU_SUB, "sub");
        alu_instr(4'h2, NONE, "add");
        short_instr(4'h8, 1, 0, NONE, "jz_z0");
        short_instr(4'h8, 0, 1, IR_RD | PC_WR, "jz_z1");
        short_instr(4'h7, 0, 1, NONE, "jc_c0");
        short_instr(4'h7, 1, 0, IR_RD | PC_WR, "jc_c1");
        short_instr(4'h6, 0, 0, IR_RD | PC_WR, "jmp");
        short_instr(4'hE, 0, 0, A_RD | OUT_WR, "out");
        short_instr(4'h0, 0, 0, NONE, "nop");
        short_instr(4'h9, 1, 1, NONE, "undef9");
        short_instr(4'hD, 1, 1, NONE, "undefD");

        fetch(4'h1, 0, 0, "lda");
        step(1, 1, 4'h1, 0, 0, 1, 3'd2, 0, IR_RD | MAR_WR, "lda_t2");
        step(1, 1, 4'h1, 0, 0, 1, 3'd3, 0, RAM_RD | A_WR, "lda_t3");
        fetch(4'h4, 0, 0, "sta");
        step(1, 1, 4'h4, 0, 0, 1, 3'd2, 0, IR_RD | MAR_WR, "sta_t2");
        step(1, 1, 4'h4, 0, 0, 1, 3'd3, 0, A_RD | RAM_WR, "sta_t3");

        // ADD stalled three cycles at T3, then resumed without skipping.
        fetch(4'h2, 0, 0, "stall");
        step(1, 1, 4'h2, 0, 0, 1, 3'd2, 0, IR_RD | MAR_WR, "stall_t2");
        for (int i = 0; i < 3; i++)
            step(0, 1, 4'h2, 0, 0, 1, 3'd3, 0, NONE, "stall_hold");
        step(1, 1, 4'h2, 0, 0, 1, 3'd3, 0, RAM_RD | B_WR, "stall_t3");
        step(1, 1, 4'h2, 0, 0, 1, 3'd4, 0, ALU_RD | A_WR | FLAGS_WR, "stall_t4");

        // Reset in the middle of an ADD abandons it.
        fetch(4'h2, 0, 0, "abort");
        step(1, 1, 4'h2, 0, 0, 1, 3'd2, 0, IR_RD | MAR_WR, "abort_t2");
        step(1, 1, 4'h2, 0, 0, 1, 3'd3, 0, RAM_RD | B_WR, "abort_t3");
        step(1, 0, 4'h2, 0, 0, 1, 3'd0, 0, NONE, "abort_rst");

        // HLT: halted from the cycle after T2, held for 20 cycles until reset.
        short_instr(4'hF, 0, 0, NONE, "hlt");
        for (int i = 0; i < 20; i++)
            step(1, 1, 4'hF, i[0], i[1], 0, 3'd0, 1, NONE, "halt_hold");
        step(1, 0, 4'hF, 0, 0, 1, 3'd0, 0, NONE, "halt_rst");
        short_instr(4'h5, 0, 0, IR_RD | A_WR, "after_halt");

        // Random run/flags over all opcodes; only the rd exclusivity is checked here.
        cur_op = 4'h0;
        for (int i = 0; i < 10000; i++) begin
            if (tstate <= 3'd1)
                cur_op = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) != 0), !(halted || $urandom_range(0, 199) == 0),
                  cur_op, 1'($urandom), 1'($urandom));
            @(posedge clk); #1;
        end
        drive(1, 1, 4'h0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: OP_W, default 4, opcode width taken from IR bits [7:4].
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr_n  input  1  reset, synchronous, active-low.
REQ-004 run  input  1  high = advance T-state each clk; low = stall.
REQ-005 ir_opcode  input  OP_W  opcode from the instruction register output; must be stable from T2 until the instruction ends.
REQ-006 carry_flag, zero_flag  input  1 each  registered ALU flags.
REQ-007 pc_rd, ir_rd, ram_rd, a_rd, alu_rd  output  1 each  bus-drive enables for PC, IR operand (low nibble), RAM, A, ALU.
REQ-008 pc_wr, mar_wr, ir_wr, ram_wr, a_wr, b_wr, out_wr  output  1 each  bus-load enables.
REQ-009 pc_inc, alu_sub, flags_wr  output  1 each  PC increment, ALU subtract select, flag register load.
REQ-010 tstate  output  3  current T-state (0-5); halted  output  1  high in HALT.

Function
REQ-011 States: T0..T5 plus HALT. State is held in registers; control outputs are a combinational decode of (state, ir_opcode, flags).
REQ-012 Fetch (all opcodes): T0 = pc_rd, mar_wr; T1 = ram_rd, ir_wr, pc_inc; T1 -> T2 unconditionally.
REQ-013 Opcodes: NOP 0000, LDA 0001, ADD 0010, SUB 0011, STA 0100, LDI 0101, JMP 0110, JC 0111, JZ 1000, OUT 1110, HLT 1111; undefined opcodes execute as NOP.
REQ-014 NOP: T2 = no outputs; -> T0.
REQ-015 LDA: T2 = ir_rd, mar_wr; T3 = ram_rd, a_wr; -> T0.
REQ-016 ADD: T2 = ir_rd, mar_wr; T3 = ram_rd, b_wr; T4 = alu_rd, a_wr, flags_wr; -> T0.
REQ-017 SUB: same as ADD, with alu_sub also asserted in T4.
REQ-018 STA: T2 = ir_rd, mar_wr; T3 = a_rd, ram_wr; -> T0.
REQ-019 LDI: T2 = ir_rd, a_wr; -> T0.
REQ-020 JMP: T2 = ir_rd, pc_wr; -> T0.
REQ-021 JC/JZ: T2 = ir_rd, pc_wr only if carry_flag/zero_flag (flag sampled in T2) is 1; -> T0 either way.
REQ-022 OUT: T2 = a_rd, out_wr; -> T0.
REQ-023 HLT: T2 -> HALT; HALT holds until reset, with halted = 1 and all other control outputs 0.
REQ-024 State T5 is reserved: if ever reached, the block returns to T0 with no outputs asserted.
REQ-025 At most one *_rd output is high in any cycle; this is an invariant of every state/opcode combination.
REQ-026 Instruction length: LDI, JMP, JC, JZ, OUT, NOP = 3 cycles; LDA, STA = 4; ADD, SUB = 5.
REQ-027 run = 0: state holds and all control outputs are 0; tstate and halted still show the held state.
REQ-028 run returning to 1 resumes at the held T-state with that state's outputs; no step is skipped or repeated.

Reset
REQ-029 clr_n = 0 at a rising clk edge: state <= T0, overriding run and HALT.
REQ-030 While clr_n = 0: all control outputs are 0, tstate = 0, halted = 0.
REQ-031 A reset during any execute step abandons the instruction; the next cycle after release is T0 fetch.

Structure
REQ-032 Shared package cpu_pkg holds the opcode constants, state encoding (T0..T5, HALT) and OP_W default.
REQ-033 One sub-module, ctrl_decode: combinational (state, opcode, flags) -> control word and next-state-is-T0 indication; control_unit holds only the state register and run/reset gating.

Verification
REQ-034 Reset then run = 1, opcode 0101 (LDI): T0 pc_rd+mar_wr; T1 ram_rd+ir_wr+pc_inc; T2 ir_rd+a_wr; next cycle tstate = 0.
REQ-035 Opcode 0011 (SUB): ram_rd+b_wr at T3; alu_rd+a_wr+flags_wr+alu_sub at T4; tstate = 0 on the 6th cycle.
REQ-036 JZ with zero_flag = 0: no pc_wr at T2; JZ with zero_flag = 1: ir_rd+pc_wr at T2.
REQ-037 Opcode 1111: halted = 1 from the cycle after T2, with outputs 0 for 20 cycles; clr_n = 0 for 1 cycle -> tstate = 0, halted = 0.
REQ-038 ADD with run dropped for 3 cycles at T3: outputs 0 and tstate = 3 held; on resume ram_rd+b_wr are asserted once, then T4.
REQ-039 All 16 opcodes, random run/flags, 10k cycles: assertion that no two *_rd outputs are ever high in the same cycle; undefined opcodes take 3 cycles.
